// File: rtl/led_stretch_pkg.sv
// Shared types and default timing for the LED event stretcher.
package led_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } stretch_state_t;

    // Defaults: 1 ms timebase at 50 MHz, 200 ms lit, 100 ms dark gap.
    localparam int unsigned DEF_N_CH      = 5;
    localparam int unsigned DEF_TICK_DIV  = 50000;
    localparam int unsigned DEF_ON_TICKS  = 200;
    localparam int unsigned DEF_GAP_TICKS = 100;
    localparam int unsigned DEF_PEND_W    = 3;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/led_event_stretcher_channel.sv
// One LED channel: IDLE -> ON -> GAP state machine with a tick-driven timer.
// With LED_STRETCH_PEND_EN defined, events seen while busy are queued in a saturating
// counter; otherwise they are dropped and flagged in ovf.
module stretch_channel
    import led_stretch_pkg::*;
#(
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    parameter int unsigned PEND_W    = DEF_PEND_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic evt,
    input  logic clr_ovf,
    output logic led,
    output logic busy,
    output logic ovf
);

    localparam int unsigned TMR_W = cnt_width((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS);
    localparam logic [TMR_W-1:0] TMR_ON  = TMR_W'(ON_TICKS);
    localparam logic [TMR_W-1:0] TMR_GAP = TMR_W'(GAP_TICKS);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    if (ON_TICKS < 1 || GAP_TICKS < 1 || PEND_W < 1) begin : g_bad_param
        $error("stretch_channel: ON_TICKS, GAP_TICKS and PEND_W must all be >= 1");
    end

    stretch_state_t   state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             expire;
    logic             enq;
    logic             lost;
    logic             ovf_d;

`ifdef LED_STRETCH_PEND_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    logic [PEND_W-1:0] pend_q, pend_d;
`endif

    assign expire = tick && (tmr_q == TMR_ONE);

    // Next state, timer reload/decrement, queue bookkeeping and overflow detection.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        enq     = 1'b0;
        lost    = 1'b0;
`ifdef LED_STRETCH_PEND_EN
        pend_d  = pend_q;
`endif
        if (tick && (state_q != ST_IDLE)) begin
            tmr_d = tmr_q - TMR_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (evt) begin
                    state_d = ST_ON;
                    tmr_d   = TMR_ON;
                end
            end
            ST_ON: begin
                if (expire) begin
                    state_d = ST_GAP;
                    tmr_d   = TMR_GAP;
                end
                enq = evt;
            end
            ST_GAP: begin
                if (expire) begin
`ifdef LED_STRETCH_PEND_EN
                    // Consume one queued event; a coincident evt replaces it (net unchanged).
                    if ((pend_q != '0) || evt) begin
                        state_d = ST_ON;
                        tmr_d   = TMR_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    if ((pend_q != '0) && !evt) begin
                        pend_d = pend_q - PEND_ONE;
                    end
`else
                    state_d = evt ? ST_ON : ST_IDLE;
                    tmr_d   = TMR_ON;
`endif
                end else begin
                    enq = evt;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef LED_STRETCH_PEND_EN
        if (enq) begin
            if (pend_q == PEND_MAX) begin
                lost = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end
`else
        lost = enq;
`endif
        // A fresh loss beats a simultaneous clear.
        ovf_d = (ovf && !clr_ovf) || lost;
    end

    // State and registered outputs; reset drops the LED immediately and discards the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            led     <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
`ifdef LED_STRETCH_PEND_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            led     <= (state_d == ST_ON);
            busy    <= (state_d != ST_IDLE);
            ovf     <= ovf_d;
`ifdef LED_STRETCH_PEND_EN
            pend_q  <= pend_d;
`endif
        end
    end

endmodule

// File: rtl/led_event_stretcher.sv
// Turns 1-cycle internal events into human-visible LED blinks, one channel per LED.
// Shared prescaler produces the timebase tick; each channel runs its own blink FSM.
// Optional feature macro: LED_STRETCH_PEND_EN (queue events that arrive while busy).
module led_event_stretcher
    import led_stretch_pkg::*;
#(
    parameter int unsigned N_CH      = DEF_N_CH,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    parameter int unsigned PEND_W    = DEF_PEND_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] evt,
    input  logic            clr_ovf,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] ovf
);

    localparam int unsigned CNT_W = cnt_width(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("led_event_stretcher: TICK_DIV must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    assign tick = (cnt_q == CNT_LAST);

    // Free-running prescaler; first tick lands on the TICK_DIV-th cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : (cnt_q + CNT_ONE);
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        stretch_channel #(
            .ON_TICKS (ON_TICKS),
            .GAP_TICKS(GAP_TICKS),
            .PEND_W   (PEND_W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .evt    (evt[ch]),
            .clr_ovf(clr_ovf),
            .led    (led[ch]),
            .busy   (busy[ch]),
            .ovf    (ovf[ch])
        );
    end

endmodule

// File: tb/tb_led_event_stretcher.sv
// Self-checking bench for led_event_stretcher: hand table, directed corner sequences and a
// randomized run against a tick-count reference model.
`timescale 1ns/1ps
module tb_led_event_stretcher;

    localparam int N_CH      = 5;
    localparam int TICK_DIV  = 4;
    localparam int ON_TICKS  = 3;
    localparam int GAP_TICKS = 2;
    localparam int PEND_W    = 2;
`ifdef LED_STRETCH_PEND_EN
    localparam int QMAX = (1 << PEND_W) - 1;
`else
    localparam int QMAX = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] evt = '0;
    logic            clr_ovf = 1'b0;
    logic [N_CH-1:0] led, busy, ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_event_stretcher #(
        .N_CH     (N_CH),
        .TICK_DIV (TICK_DIV),
        .ON_TICKS (ON_TICKS),
        .GAP_TICKS(GAP_TICKS),
        .PEND_W   (PEND_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .evt    (evt),
        .clr_ovf(clr_ovf),
        .led    (led),
        .busy   (busy),
        .ovf    (ovf)
    );

    // Reference model: phases end when the global tick count reaches a deadline.
    int              m_k, m_tc;
    int              m_mode[N_CH];   // 0 dark/idle, 1 lit, 2 gap
    int              m_dead[N_CH];
    int              m_q[N_CH];
    logic [N_CH-1:0] m_ovf;

    function automatic void model_reset();
        m_k = 0;
        m_tc = 0;
        m_ovf = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_mode[ch] = 0;
            m_dead[ch] = 0;
            m_q[ch] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [N_CH-1:0] e, input logic c);
        bit tk;
        bit lost;
        bit enq;
        tk = ((m_k % TICK_DIV) == TICK_DIV - 1);
        if (tk) m_tc++;
        m_k++;
        for (int ch = 0; ch < N_CH; ch++) begin
            lost = 0;
            enq = 0;
            if (m_mode[ch] == 0) begin
                if (e[ch]) begin
                    m_mode[ch] = 1;
                    m_dead[ch] = m_tc + ON_TICKS;
                end
            end else if (m_mode[ch] == 1) begin
                if (tk && m_tc == m_dead[ch]) begin
                    m_mode[ch] = 2;
                    m_dead[ch] = m_tc + GAP_TICKS;
                end
                enq = e[ch];
            end else begin
                if (tk && m_tc == m_dead[ch]) begin
                    if (m_q[ch] > 0 || e[ch]) begin
                        if (m_q[ch] > 0 && !e[ch]) m_q[ch]--;
                        m_mode[ch] = 1;
                        m_dead[ch] = m_tc + ON_TICKS;
                    end else begin
                        m_mode[ch] = 0;
                    end
                end else begin
                    enq = e[ch];
                end
            end
            if (enq) begin
                if (m_q[ch] < QMAX) m_q[ch]++;
                else lost = 1;
            end
            m_ovf[ch] = (m_ovf[ch] && !c) || lost;
        end
    endfunction

    function automatic logic [N_CH-1:0] m_out(input int sel);
        logic [N_CH-1:0] r;
        r = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (sel == 0) r[ch] = (m_mode[ch] == 1);
            else if (sel == 1) r[ch] = (m_mode[ch] != 0);
            else r[ch] = m_ovf[ch];
        end
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [N_CH-1:0] act,
                             input logic [N_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock, advance the model, compare all outputs just after the edge.
    task automatic step(input logic [N_CH-1:0] e, input logic c);
        evt = e;
        clr_ovf = c;
        @(posedge clk);
        model_edge(e, c);
        #1;
        check_vec("model_led", led, m_out(0));
        check_vec("model_busy", busy, m_out(1));
        check_vec("model_ovf", ovf, m_out(2));
    endtask

    task automatic do_reset();
        evt = '0;
        clr_ovf = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Events on one channel every other cycle from cycle 0, then count and time the blinks.
    task automatic blink_seq(input int ch, input int n_evt);
        logic [N_CH-1:0] e;
        logic [N_CH-1:0] mask;
        logic            prev;
        int blinks, run, lit_bad, gap_bad, others;
        blinks = 0; run = 0; lit_bad = 0; gap_bad = 0; others = 0; prev = 1'b0;
        mask = '0;
        mask[ch] = 1'b1;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            e = '0;
            if (k < 2 * n_evt && (k % 2) == 0) e[ch] = 1'b1;
            step(e, 1'b0);
            if ((led & ~mask) != '0) others++;
            if (led[ch] !== prev) begin
                if (prev) begin
                    if (run < 9 || run > 12) lit_bad++;
                end else if (blinks > 0) begin
                    if (run < 5 || run > 8) gap_bad++;
                end
                if (!prev) blinks++;
                prev = led[ch];
                run = 1;
            end else begin
                run++;
            end
        end
        check_int("blink_count", blinks, 1 + ((n_evt - 1 < QMAX) ? n_evt - 1 : QMAX));
        check_int("lit_len_bad", lit_bad, 0);
        check_int("gap_len_bad", gap_bad, 0);
        check_int("other_leds_lit", others, 0);
        check_int("busy_after", int'(busy[ch]), 0);
        check_int("ovf_after", int'(ovf[ch]), (n_evt - 1 > QMAX) ? 1 : 0);
    endtask

    typedef struct {
        logic [N_CH-1:0] e;
        logic            c;
        int              n;
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] busy;
        logic [N_CH-1:0] ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [N_CH-1:0] e;
        int rises;
        int dens;

        // Reset state and quiet operation.
        do_reset();
        check_vec("reset_led", led, '0);
        check_vec("reset_busy", busy, '0);
        check_vec("reset_ovf", ovf, '0);
        for (int k = 0; k < 100; k++) step('0, 1'b0);
        check_vec("quiet_led", led, '0);

        // Single blink on ch0, then all channels together, then an evt on the gap-expiry cycle.
        tbl[0]  = '{5'h01, 1'b0, 1,  5'h01, 5'h01, 5'h00};
        tbl[1]  = '{5'h00, 1'b0, 10, 5'h01, 5'h01, 5'h00};
        tbl[2]  = '{5'h00, 1'b0, 8,  5'h00, 5'h01, 5'h00};
        tbl[3]  = '{5'h00, 1'b0, 5,  5'h00, 5'h00, 5'h00};
        tbl[4]  = '{5'h1f, 1'b0, 1,  5'h1f, 5'h1f, 5'h00};
        tbl[5]  = '{5'h00, 1'b0, 10, 5'h1f, 5'h1f, 5'h00};
        tbl[6]  = '{5'h00, 1'b0, 8,  5'h00, 5'h1f, 5'h00};
        tbl[7]  = '{5'h1f, 1'b0, 1,  5'h1f, 5'h1f, 5'h00};
        tbl[8]  = '{5'h00, 1'b0, 11, 5'h1f, 5'h1f, 5'h00};
        tbl[9]  = '{5'h00, 1'b0, 8,  5'h00, 5'h1f, 5'h00};
        tbl[10] = '{5'h00, 1'b1, 4,  5'h00, 5'h00, 5'h00};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(tbl[i].e, tbl[i].c);
                check_vec("tbl_led", led, tbl[i].led);
                check_vec("tbl_busy", busy, tbl[i].busy);
                check_vec("tbl_ovf", ovf, tbl[i].ovf);
            end
        end

        // Queued blinks: three extra events on ch1; six events on ch2 overflow a full queue.
        blink_seq(1, 4);
        blink_seq(2, 6);
        step('0, 1'b1);
        check_int("clr_ovf_ch2", int'(ovf[2]), 0);

        // clr_ovf in the same cycle as a fresh loss: ovf must stay set.
        do_reset();
        step(5'h10, 1'b0);
        for (int i = 0; i <= QMAX; i++) step(5'h10, (i == QMAX));
        check_int("ovf_set_beats_clr", int'(ovf[4]), 1);

        // Asynchronous reset mid-blink with events queued on ch3.
        do_reset();
        for (int k = 0; k < 6; k++) step((k < 3) ? 5'h08 : 5'h00, 1'b0);
        check_int("ch3_lit_before_rst", int'(led[3]), 1);
        evt = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_rst_led", led, '0);
        check_vec("async_rst_busy", busy, '0);
        check_vec("async_rst_ovf", ovf, '0);
        do_reset();
        rises = 0;
        for (int k = 0; k < 60; k++) begin
            step('0, 1'b0);
            if (led[3]) rises++;
        end
        check_int("no_blink_after_rst", rises, 0);

        // Randomized traffic against the model at several event densities.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ((k % 500) == 0) dens = (k / 500 % 3 == 0) ? 3 : ((k / 500 % 3 == 1) ? 12 : 40);
            for (int ch = 0; ch < N_CH; ch++) e[ch] = ($urandom_range(0, dens) == 0);
            step(e, ($urandom_range(0, 30) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
